// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// Optional macro MULT_DIV_UNSIGNED_EN adds unsigned_op for MULTU/DIVU.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Shared datapath register: {accumulator/remainder (WIDTH+2), Q (WIDTH)}.
  // Two guard bits let Booth add a zero-extended WIDTH-bit multiplicand.
  localparam int PW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX
  } state_t;

  logic uns;
`ifdef MULT_DIV_UNSIGNED_EN
  assign uns = unsigned_op;
`else
  assign uns = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               dz_q, dz_d;
  logic               corr_q, corr_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH+1:0]   m_q, m_d;
  logic [PW-1:0]      p_q, p_d;
  logic               qm1_q, qm1_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+1:0]   booth_sum;
  logic [PW-1:0]      div_sh;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   q_raw, r_raw;

  // Operand magnitudes, Booth add/sub and restoring-divide trial subtract.
  always_comb begin
    a_neg = ~uns & a[WIDTH-1];
    b_neg = ~uns & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
    unique case ({p_q[0], qm1_q})
      2'b01:   booth_sum = p_q[PW-1:WIDTH] + m_q;
      2'b10:   booth_sum = p_q[PW-1:WIDTH] - m_q;
      default: booth_sum = p_q[PW-1:WIDTH];
    endcase
    div_sh = {p_q[PW-2:0], 1'b0};
    trial  = div_sh[PW-1:WIDTH] - m_q;
    q_raw  = p_q[WIDTH-1:0];
    r_raw  = p_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath control for IDLE/MULT/DIV/FIX.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dz_d       = dz_q;
    corr_d     = corr_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    m_d        = m_q;
    p_d        = p_q;
    qm1_d      = qm1_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          busy_d = 1'b1;
          cnt_d  = CNT_W'(WIDTH - 1);
          qm1_d  = 1'b0;
          if (!op) begin
            m_d     = uns ? {2'b00, a} : {{2{a[WIDTH-1]}}, a};
            p_d     = {{(WIDTH + 2){1'b0}}, b};
            corr_d  = uns & b[WIDTH-1];
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            dz_d    = 1'b0;
            state_d = S_MULT;
          end else begin
            m_d     = {2'b00, b_mag};
            p_d     = {{(WIDTH + 2){1'b0}}, a_mag};
            corr_d  = 1'b0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (b == '0);
            state_d = (b == '0) ? S_FIX : S_DIV;
          end
        end
      end
      S_MULT: begin
        p_d   = {booth_sum[WIDTH+1], booth_sum, p_q[WIDTH-1:1]};
        qm1_d = p_q[0];
        if (cnt_q == '0) state_d = S_FIX;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_DIV: begin
        p_d = div_sh;
        if (!trial[WIDTH+1]) begin
          p_d[PW-1:WIDTH] = trial;
          p_d[0]          = 1'b1;
        end
        if (cnt_q == '0) state_d = S_FIX;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (!dz_q) begin
          if (op_q) begin
            lo_d = qneg_q ? (~q_raw + 1'b1) : q_raw;
            hi_d = rneg_q ? (~r_raw + 1'b1) : r_raw;
          end else begin
            lo_d = q_raw;
            hi_d = r_raw + (corr_q ? m_q[WIDTH-1:0] : '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      dz_q       <= 1'b0;
      corr_q     <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      m_q        <= '0;
      p_q        <= '0;
      qm1_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dz_q       <= dz_d;
      corr_q     <= corr_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      m_q        <= m_d;
      p_q        <= p_d;
      qm1_q      <= qm1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed table-driven bench for mult_div_unit.
// Unsigned vectors are included when MULT_DIV_UNSIGNED_EN is defined.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op    = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
  logic         unsigned_op = 1'b0;
`endif
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op(op),
`ifdef MULT_DIV_UNSIGNED_EN
    .unsigned_op(unsigned_op),
`endif
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request for one edge, then scramble the inputs.
  task automatic issue(input logic o_i, input logic u_i,
                       input logic [31:0] a_i, input logic [31:0] b_i);
    start = 1'b1;
    op    = o_i;
    a     = a_i;
    b     = b_i;
`ifdef MULT_DIV_UNSIGNED_EN
    unsigned_op = u_i;
`else
    if (u_i) $display("note: unsigned vector issued in signed build");
`endif
    @(posedge clock);
    #1;
    start = 1'b0;
    op    = ~o_i;
    a     = ~a_i;
    b     = b_i ^ 32'h5A5A_0001;
  endtask

  // Count edges until done; busy must be high until then, low with done.
  task automatic wait_done(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clock);
      #1;
      n++;
    end
    if (done && busy) busy_ok = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit bok;
    issue(v.op, v.uns, v.a, v.b);
    wait_done(n, bok);
    check($sformatf("vec%0d latency", idx), 32'(n), 32'(v.lat));
    check($sformatf("vec%0d busy", idx), 32'(bok), 32'd1);
    check($sformatf("vec%0d hi", idx), hi, v.hi);
    check($sformatf("vec%0d lo", idx), lo, v.lo);
    check($sformatf("vec%0d div_zero", idx), 32'(div_zero), 32'(v.dz));
  endtask

  initial begin
    int n;
    bit bok;

    // op, uns, a, b, hi, lo, dz, latency
    vq.push_back(vec_t'{1'b0, 1'b0, 32'd7, 32'hFFFFFFFD,
                        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33});
    vq.push_back(vec_t'{1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,
                        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33});
    vq.push_back(vec_t'{1'b0, 1'b0, 32'd3, 32'd4,
                        32'd0, 32'd12, 1'b0, 33});
    vq.push_back(vec_t'{1'b1, 1'b0, 32'd5, 32'd0,
                        32'd0, 32'd12, 1'b1, 1});
    vq.push_back(vec_t'{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF,
                        32'd0, 32'h80000000, 1'b0, 33});
    vq.push_back(vec_t'{1'b0, 1'b0, 32'h80000000, 32'h80000000,
                        32'h40000000, 32'd0, 1'b0, 33});
    vq.push_back(vec_t'{1'b1, 1'b0, 32'd100, 32'd7,
                        32'd2, 32'd14, 1'b0, 33});
    vq.push_back(vec_t'{1'b1, 1'b0, 32'd7, 32'hFFFFFFFE,
                        32'd1, 32'hFFFFFFFD, 1'b0, 33});
    vq.push_back(vec_t'{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                        32'd0, 32'd1, 1'b0, 33});
    vq.push_back(vec_t'{1'b0, 1'b0, 32'h00010000, 32'h00010000,
                        32'd1, 32'd0, 1'b0, 33});
    vq.push_back(vec_t'{1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF,
                        32'h3FFFFFFF, 32'd1, 1'b0, 33});
    vq.push_back(vec_t'{1'b0, 1'b0, 32'h80000000, 32'd1,
                        32'hFFFFFFFF, 32'h80000000, 1'b0, 33});
    vq.push_back(vec_t'{1'b1, 1'b0, 32'hFFFFFFF8, 32'hFFFFFFFD,
                        32'hFFFFFFFE, 32'd2, 1'b0, 33});
    vq.push_back(vec_t'{1'b1, 1'b0, 32'h80000000, 32'd0,
                        32'hFFFFFFFE, 32'd2, 1'b1, 1});
`ifdef MULT_DIV_UNSIGNED_EN
    vq.push_back(vec_t'{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                        32'hFFFFFFFE, 32'd1, 1'b0, 33});
    vq.push_back(vec_t'{1'b1, 1'b1, 32'hFFFFFFFF, 32'd2,
                        32'd1, 32'h7FFFFFFF, 1'b0, 33});
`endif

    // Reset state
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Back-to-back table: each request issues in the previous done cycle
    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // done is a single-cycle pulse
    @(posedge clock);
    #1;
    check("done pulse", 32'(done), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    // start while busy is ignored
    issue(1'b0, 1'b0, 32'd3, 32'd5);
    repeat (5) @(posedge clock);
    #1;
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(n, bok);
    check("ignore latency", 32'(n + 6), 32'd33);
    check("ignore busy", 32'(bok), 32'd1);
    check("ignore hi", hi, 32'd0);
    check("ignore lo", lo, 32'd15);
    @(posedge clock);
    #1;
    check("ignore no relaunch", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a divide
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post-rst idle", 32'(busy), 32'd0);
    run_vec(vec_t'{1'b0, 1'b0, 32'd6, 32'd7,
                   32'd0, 32'd42, 1'b0, 33}, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
